// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory port, redirect request and decode-side handshake.
// "master" is the fetch unit's view; "slave" is the memory/decode/redirect environment.
interface instruction_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_ins;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic        out_err;

  modport master (
    output imem_addr,
    input  imem_ins,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_ins,
    output out_err
  );

  modport slave (
    input  imem_addr,
    output imem_ins,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_ins,
    input  out_err
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Pipeline front end: owns the PC, fetches one word per cycle into a small queue
// and hands {pc, ins, err} entries to decode; redirects flush the queue and reload the PC.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 2,
  parameter int          IM_WORDS = 1024
) (
  input logic                     clock,
  input logic                     reset,
  instruction_fetch_unit_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  // 33-bit window bounds so a window ending at 2^32 cannot wrap to zero.
  localparam logic [32:0] PC_LO = {1'b0, RESET_PC};
  localparam logic [32:0] PC_HI = PC_LO + (33'(IM_WORDS) << 2);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] pc_mem_q  [DEPTH];
  logic [31:0] ins_mem_q [DEPTH];
  logic        err_mem_q [DEPTH];

  logic        fetch_err;
  logic [31:0] fetch_ins;
  logic        out_valid;
  logic        pop;
  logic        can_fetch;
  logic        push;

  assign bus.imem_addr = pc_q;

  always_comb begin
    fetch_err = (pc_q[1:0] != 2'b00)
             || ({1'b0, pc_q} < PC_LO)
             || ({1'b0, pc_q} >= PC_HI);
    fetch_ins = fetch_err ? 32'h0000_0000 : bus.imem_ins;
  end

  // Outputs are forced to zero while reset is held, even before the reset edge lands.
  assign out_valid = reset && (count_q != '0);
  assign pop       = out_valid && bus.out_ready;
  assign can_fetch = (count_q < DEPTH_C) || pop;
  assign push      = can_fetch && !bus.redirect_valid;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + 32'd4;
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: it is only observed through count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem_q[tail_q]  <= pc_q;
      ins_mem_q[tail_q] <= fetch_ins;
      err_mem_q[tail_q] <= fetch_err;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_valid ? pc_mem_q[head_q]  : 32'h0000_0000;
  assign bus.out_ins   = out_valid ? ins_mem_q[head_q] : 32'h0000_0000;
  assign bus.out_err   = out_valid ? err_mem_q[head_q] : 1'b0;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front end of the pipeline. It owns the program counter, drives the word address into the instruction memory, and captures the combinational instruction word each cycle. Fetched {pc, instruction, error} entries are buffered in a small queue and presented to the decode stage over a valid/ready handshake. Branch/jump/exception redirects flush the queue and reload the PC.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
DEPTH, 2, fetch queue entries (power of two, >=2).
IM_WORDS, 1024, instruction memory size in words; sets the legal fetch window.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
imem_addr  output  32  byte address to instruction memory, equals current PC
imem_ins  input  32  instruction word returned combinationally for imem_addr
redirect_valid  input  1  load new PC and flush queue this cycle
redirect_pc  input  32  target PC for redirect
out_valid  output  1  head entry valid
out_ready  input  1  decode stage accepts head entry
out_pc  output  32  PC of head entry
out_ins  output  32  instruction of head entry
out_err  output  1  head entry is a fetch fault (AdEL)

Behaviour:
- Reset (reset==0 at rising edge): pc<=RESET_PC; queue emptied (count=0, head/tail pointers 0). While reset is low, out_valid=0, out_pc=0, out_ins=0, out_err=0. A reset mid-stream discards all entries.
- imem_addr = pc, combinational. Queue outputs come from registered storage; out_* = head entry when count>0, else zeros.
- pop = out_valid && out_ready.
- can_fetch = (count<DEPTH) || pop.
- Normal cycle (no redirect, can_fetch): push {pc, ins, err}; pc<=pc+4 (32-bit wrap).
  - err=1 when pc[1:0]!=0 or pc outside [RESET_PC, RESET_PC+4*IM_WORDS). In that case ins is pushed as 32'h0000_0000 (nop).
- Queue full with no pop: no push; pc holds; imem_addr stable.
- Simultaneous push and pop: count unchanged and pointers both advance. Wrap-around is mod DEPTH.
- Redirect priority: redirect_valid overrides everything else.
  - A pop completing in the same cycle counts as consumed.
  - All remaining entries are discarded; count<=0; no push that cycle.
  - pc<=redirect_pc unmodified; a misaligned target produces an err entry when fetched.
  - Delay-slot ordering is the requester's responsibility: it asserts the redirect only after the slot instruction has been accepted.
- Latency:
  - First valid output appears 2 cycles after the first rising edge with reset==1 (edge 1 fetches RESET_PC; out_valid high after edge 1, visible in cycle 2).
  - After a redirect in cycle N, the target entry is valid in cycle N+2.
- Throughput: one instruction per cycle when out_ready is held high.
- An err entry is handled like a normal entry (handshake, flush). Fetch continues past it sequentially.
- Back-to-back redirects: the last one wins; each flushes.
- No combinational path from out_ready or redirect_* to out_*.

Test Plan:
- Reset release, out_ready=1, imem holds sequential words -> out_valid rises cycle 2; out_pc 3000, 3004, 3008 … on consecutive cycles with matching out_ins, no bubbles.
- out_ready=0 for 5 cycles after first valid -> queue holds DEPTH=2 entries (3000, 3004); imem_addr frozen at 3008; on out_ready=1, entries emerge in order 3000, 3004, 3008 with no loss or duplicate.
- redirect_valid with redirect_pc=32'h0000_3100 while queue is full and out_ready=1 -> head 3000 consumed that cycle; 3004 discarded; next valid out_pc=3100 two cycles later.
- redirect_pc=32'h0000_3102 -> entry out_pc=3102, out_err=1, out_ins=0; next entry 3106, err=1.
- Sequential fetch past RESET_PC+4*IM_WORDS-4 (pc 3FFC -> 4000) -> entry at 4000 has out_err=1, out_ins=0.
- reset low for one cycle while queue is full and a redirect is pending -> out_valid=0 the following cycle; fetch restarts at 3000, redirect ignored.
